// File: rtl/rvm_mem_arbiter.sv
// rvm_mem_arbiter: shares one memory bus between instruction fetch and load/store.
//
// One transaction runs at a time (IDLE -> REQ -> RSP -> IDLE). The data port wins
// arbitration unless fetch has already waited through MAX_DATA_RUN data grants. A
// response that stalls in RSP is completed with an error after TIMEOUT cycles.
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request and address (held until if_done)
//   if_done/if_rdata/if_error       fetch completion pulse, data and error
//   d_req/d_addr/d_wen/d_strb/d_wdata  load/store request and attributes
//   d_done/d_rdata/d_error          load/store completion pulse, data and error
//   mem_req/mem_addr/mem_wen/mem_strb/mem_wdata  registered bus request
//   mem_gnt                         bus accepted the request this cycle
//   mem_recv/mem_rdata/mem_error    bus response
module rvm_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_error,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_wen,
    input  logic [DATA_W/8-1:0] d_strb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_error,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_strb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_recv,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_error
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RUN_W  = $clog2(MAX_DATA_RUN + 1);
    localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RUN_W-1:0] RunMax  = RUN_W'(MAX_DATA_RUN);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e              state_q;
    logic                owner_q;  // 1 = data port owns the current transaction
    logic [RUN_W-1:0]    run_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wen_q;
    logic [STRB_W-1:0]   mem_strb_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_done_q, d_done_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                if_error_q, d_error_q;

    logic                grant_d, grant_f;
    logic                complete;
    logic [DATA_W-1:0]   cpl_rdata;
    logic                cpl_error;

    always_comb begin
        grant_d = d_req && (!if_req || (run_q < RunMax));
        grant_f = if_req && !grant_d;
    end

    // Completion comes from a same-cycle gnt+recv in REQ, a response in RSP, or the
    // timeout expiring in RSP (which forces zero data and an error).
    always_comb begin
        complete  = 1'b0;
        cpl_rdata = mem_rdata;
        cpl_error = mem_error;
        case (state_q)
            StReq: complete = mem_gnt && mem_recv;
            StRsp: begin
                if (mem_recv) begin
                    complete = 1'b1;
                end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
                    complete  = 1'b1;
                    cpl_rdata = '0;
                    cpl_error = 1'b1;
                end
            end
            default: complete = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            run_q       <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_strb_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_error_q  <= 1'b0;
            d_error_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if (complete) begin
                if (owner_q) begin
                    d_done_q  <= 1'b1;
                    d_rdata_q <= cpl_rdata;
                    d_error_q <= cpl_error;
                end else begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= cpl_rdata;
                    if_error_q <= cpl_error;
                end
            end

            case (state_q)
                StIdle: begin
                    if (grant_d || grant_f) begin
                        owner_q     <= grant_d;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= grant_d ? d_addr : if_addr;
                        mem_wen_q   <= grant_d && d_wen;
                        mem_strb_q  <= grant_d ? d_strb : '0;
                        mem_wdata_q <= grant_d ? d_wdata : '0;
                        // Run length only grows while fetch is actually waiting.
                        if (grant_d && if_req) begin
                            run_q <= (run_q == RunMax) ? run_q : run_q + 1'b1;
                        end else begin
                            run_q <= '0;
                        end
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        tmo_q     <= '0;
                        state_q   <= mem_recv ? StIdle : StRsp;
                    end
                end
                StRsp: begin
                    if (complete) begin
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_strb  = mem_strb_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_error  = if_error_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_error   = d_error_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Testbench for rvm_mem_arbiter: directed scenarios followed by a randomized run,
// checked against a transaction-level model of arbitration and completion.
module tb_rvm_mem_arbiter;

    localparam int unsigned MAX_RUN = 4;
    localparam int unsigned TMO     = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_error;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [3:0]  d_strb;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_error;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_recv;
    logic [31:0] mem_rdata;
    logic        mem_error;

    rvm_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_DATA_RUN(MAX_RUN),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .if_error (if_error),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wen    (d_wen),
        .d_strb   (d_strb),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .d_error  (d_error),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_strb (mem_strb),
        .mem_wdata(mem_wdata),
        .mem_gnt  (mem_gnt),
        .mem_recv (mem_recv),
        .mem_rdata(mem_rdata),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    // Model state: consecutive data grants while fetch waits, and held response values.
    int          run_m = 0;
    logic [31:0] e_if_rdata = 32'h0;
    logic [31:0] e_d_rdata  = 32'h0;
    logic        e_if_err   = 1'b0;
    logic        e_d_err    = 1'b0;
    bit          wd;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_no_done(input string tag);
        chk({tag, "_if_done"}, if_done, 1'b0);
        chk({tag, "_d_done"}, d_done, 1'b0);
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_addr  = $urandom & 32'hffff_fffc;
        d_wen   = 1'($urandom_range(0, 1));
        d_strb  = 4'($urandom);
        d_wdata = $urandom;
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom & 32'hffff_fffc;
    endtask

    // Runs one transaction from the arbitration edge to the done pulse. Call at a
    // negedge with requests already driven and the arbiter about to be in IDLE.
    // rsp_dly: 0 = recv with gnt, k>0 = recv k cycles after gnt, <0 = never (timeout).
    task automatic serve(input int gnt_dly, input int rsp_dly, input logic [31:0] rd,
                         input logic er, output bit won_d);
        logic [31:0] ea, ewd, erd;
        logic        ew, eer;
        logic [3:0]  es;
        bit          to;
        won_d = d_req && (!if_req || (run_m < int'(MAX_RUN)));
        if (won_d && if_req) run_m++;
        else run_m = 0;
        ea  = won_d ? d_addr : if_addr;
        ew  = won_d ? d_wen : 1'b0;
        es  = won_d ? d_strb : 4'h0;
        ewd = won_d ? d_wdata : 32'h0;
        to  = (rsp_dly < 0);
        erd = to ? 32'h0 : rd;
        eer = to ? 1'b1 : er;

        tick();
        chk("mem_req_rise", mem_req, 1'b1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wen", mem_wen, ew);
        chk("mem_strb", mem_strb, es);
        chk("mem_wdata", mem_wdata, ewd);
        chk_no_done("issue");
        chk("if_rdata_hold", if_rdata, e_if_rdata);
        chk("d_rdata_hold", d_rdata, e_d_rdata);
        for (int i = 0; i < gnt_dly; i++) begin
            tick();
            chk("mem_req_hold", mem_req, 1'b1);
            chk("mem_addr_hold", mem_addr, ea);
            chk("mem_wdata_hold", mem_wdata, ewd);
            chk("mem_strb_hold", mem_strb, es);
            chk_no_done("wait_gnt");
        end
        mem_gnt = 1'b1;
        if (rsp_dly == 0) begin
            mem_recv  = 1'b1;
            mem_rdata = rd;
            mem_error = er;
        end
        tick();
        mem_gnt   = 1'b0;
        mem_recv  = 1'b0;
        mem_error = 1'b0;
        mem_rdata = $urandom;
        chk("mem_req_drop", mem_req, 1'b0);
        if (to) begin
            for (int i = 0; i < int'(TMO); i++) begin
                chk_no_done("rsp_wait");
                tick();
            end
        end else if (rsp_dly > 0) begin
            for (int i = 1; i < rsp_dly; i++) begin
                chk_no_done("rsp_wait");
                tick();
            end
            chk_no_done("rsp_wait");
            mem_recv  = 1'b1;
            mem_rdata = rd;
            mem_error = er;
            tick();
            mem_recv  = 1'b0;
            mem_error = 1'b0;
            mem_rdata = $urandom;
        end
        if (won_d) begin
            e_d_rdata = erd;
            e_d_err   = eer;
        end else begin
            e_if_rdata = erd;
            e_if_err   = eer;
        end
        chk("if_done", if_done, !won_d);
        chk("d_done", d_done, won_d);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("if_error", if_error, e_if_err);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("d_error", d_error, e_d_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wen"}, mem_wen, 1'b0);
        chk({tag, "_mem_strb"}, mem_strb, 4'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk_no_done(tag);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_if_error"}, if_error, 1'b0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_d_error"}, d_error, 1'b0);
    endtask

    initial begin
        resetn    = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        d_req     = 1'b0;
        d_addr    = 32'h0;
        d_wen     = 1'b0;
        d_strb    = 4'h0;
        d_wdata   = 32'h0;
        mem_gnt   = 1'b0;
        mem_recv  = 1'b0;
        mem_rdata = 32'h0;
        mem_error = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Bus activity while idle must be ignored.
        mem_gnt   = 1'b1;
        mem_recv  = 1'b1;
        mem_rdata = 32'h5555_aaaa;
        tick();
        tick();
        mem_gnt  = 1'b0;
        mem_recv = 1'b0;
        chk_all_zero("idle_noise");

        // Fetch only, gnt one cycle after request, recv two cycles after gnt.
        if_req  = 1'b1;
        if_addr = 32'h100;
        serve(1, 2, 32'h13, 1'b0, wd);
        chk("t1_winner_fetch", wd, 1'b0);

        // Both held: data wins MAX_RUN times, then fetch, repeating.
        new_d();
        for (int i = 0; i < 10; i++) begin
            serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom,
                  1'b0, wd);
            chk("t2_grant_seq", wd, (i % 5) != 4);
            if (wd) new_d();
            else new_if();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        chk_no_done("t2_after");
        chk("t2_idle_mem_req", mem_req, 1'b0);

        // Store with gnt+recv in the same cycle, attributes held while waiting for gnt.
        d_req   = 1'b1;
        d_addr  = 32'h200;
        d_wen   = 1'b1;
        d_strb  = 4'hf;
        d_wdata = 32'hdead_beef;
        serve(2, 0, 32'h0, 1'b0, wd);
        chk("t3_winner_data", wd, 1'b1);
        d_req = 1'b0;

        // Bus error on a fetch response.
        if_req  = 1'b1;
        if_addr = 32'h104;
        serve(0, 1, 32'h1234_5678, 1'b1, wd);
        if_req = 1'b0;

        // Load with no response: timeout error after TMO cycles in RSP.
        d_req  = 1'b1;
        d_addr = 32'h208;
        d_wen  = 1'b0;
        serve(0, -1, 32'hffff_ffff, 1'b0, wd);
        chk("t4_timeout_rdata", d_rdata, 32'h0);
        chk("t4_timeout_error", d_error, 1'b1);
        d_req     = 1'b0;
        mem_recv  = 1'b1;
        mem_rdata = 32'hbad0_bad0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_no_done("t4_late_recv");
            chk("t4_late_mem_req", mem_req, 1'b0);
        end
        mem_recv = 1'b0;
        chk("t4_rdata_held", d_rdata, 32'h0);

        // Async reset while in RSP.
        d_req  = 1'b1;
        d_addr = 32'h300;
        tick();
        chk("t6_mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        d_req     = 1'b0;
        mem_recv  = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        chk_no_done("t6_in_reset");
        mem_recv   = 1'b0;
        resetn     = 1'b1;
        run_m      = 0;
        e_if_rdata = 32'h0;
        e_d_rdata  = 32'h0;
        e_if_err   = 1'b0;
        e_d_err    = 1'b0;
        tick();
        chk_all_zero("t6_after");
        if_req  = 1'b1;
        if_addr = 32'h400;
        serve(1, 1, 32'h0bad_cafe, 1'b0, wd);
        chk("t6_post_reset_fetch", wd, 1'b0);
        if_req = 1'b0;

        // Randomized traffic against the model.
        new_d();
        for (int n = 0; n < 60; n++) begin
            int rsp;
            rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            serve(int'($urandom_range(0, 3)), rsp, $urandom, 1'($urandom_range(0, 1)), wd);
            if (wd) d_req = 1'b0;
            else if_req = 1'b0;
            if (!d_req && ($urandom_range(0, 3) != 0)) new_d();
            if (!if_req && ($urandom_range(0, 3) != 0)) new_if();
            if (!if_req && !d_req) begin
                mem_gnt   = 1'b1;
                mem_recv  = 1'b1;
                mem_rdata = $urandom;
                tick();
                mem_gnt  = 1'b0;
                mem_recv = 1'b0;
                chk("rnd_idle_mem_req", mem_req, 1'b0);
                chk_no_done("rnd_idle");
                new_if();
                if ($urandom_range(0, 1) == 1) new_d();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
